// File: rtl/m3_lossless_decoder.sv
// Milestone 3 lossless decoder: unpacks the variable-length coefficient stream from SRAM,
// dequantizes each coefficient with power-of-two shifts and writes block-major words for M2.
module m3_lossless_decoder #(
    parameter logic [17:0] IN_BASE      = 18'd76800,
    parameter logic [17:0] OUT_BASE     = 18'd0,
    parameter logic [11:0] NUM_BLOCKS   = 12'd2400,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        CLOCK_50_I,
    input  logic        resetn,
    input  logic        Start,
    input  logic [15:0] SRAM_read_data,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        Done,
    output logic        Error
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_FILL, S_DECODE, S_EMIT, S_BLK_END, S_DONE
    } state_t;

    localparam logic [3:0] RD_LAT = 4'(READ_LATENCY);

    // Zigzag position k -> row*8+col (standard JPEG scan).
    localparam logic [5:0] ZIGZAG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [2:0] q_shift(input logic q, input logic [3:0] s);
        logic [2:0] sh;
        if (!q) begin
            if (s == 4'd0)      sh = 3'd3;
            else if (s == 4'd1) sh = 3'd2;
            else if (s <= 4'd3) sh = 3'd3;
            else if (s <= 4'd7) sh = 3'd4;
            else                sh = 3'd5;
        end else begin
            if (s == 4'd0)      sh = 3'd3;
            else if (s <= 4'd3) sh = 3'd1;
            else if (s <= 4'd7) sh = 3'd2;
            else                sh = 3'd3;
        end
        return sh;
    endfunction

    state_t       state;
    logic [17:0]  rd_ptr;
    logic [11:0]  blk;
    logic [6:0]   k;
    logic [31:0]  bit_buf;
    logic [5:0]   bit_cnt;
    logic [3:0]   rd_wait;
    logic         hdr_idx;
    logic         qsel;
    logic [6:0]   emit_left;

    logic [5:0]         zz;
    logic [3:0]         diag;
    logic [17:0]        wr_addr;
    logic [3:0]         dec_len;
    logic signed [15:0] dec_val;
    logic               dec_coef;
    logic [6:0]         dec_run;
    logic [6:0]         room;
    logic               run_ovf;
    logic [6:0]         emit_n;
    logic [15:0]        coef_word;

    always_comb begin
        zz        = ZIGZAG[k[5:0]];
        diag      = {1'b0, zz[5:3]} + {1'b0, zz[2:0]};
        wr_addr   = OUT_BASE + {blk, 6'd0} + {12'd0, zz};
        room      = 7'd64 - k;
        dec_len   = 4'd0;
        dec_val   = '0;
        dec_coef  = 1'b0;
        dec_run   = 7'd0;
        if (!bit_buf[31]) begin
            dec_coef = 1'b1;
            if (!bit_buf[30]) begin
                dec_len = 4'd5;
                dec_val = {{13{bit_buf[29]}}, bit_buf[29:27]};
            end else begin
                dec_len = 4'd8;
                dec_val = {{10{bit_buf[29]}}, bit_buf[29:24]};
            end
        end else if (!bit_buf[30]) begin
            dec_len = 4'd5;
            dec_run = (bit_buf[29:27] == 3'd0) ? 7'd8 : {4'd0, bit_buf[29:27]};
        end else if (!bit_buf[29]) begin
            dec_len = 4'd3;
            dec_run = room;
        end else begin
            dec_coef = 1'b1;
            dec_len  = 4'd12;
            dec_val  = {{7{bit_buf[28]}}, bit_buf[28:20]};
        end
        run_ovf   = !dec_coef && (dec_run > room);
        emit_n    = dec_coef ? 7'd1 : (run_ovf ? room : dec_run);
        coef_word = dec_val <<< q_shift(qsel, diag);
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state           <= S_IDLE;
            rd_ptr          <= '0;
            blk             <= '0;
            k               <= '0;
            bit_buf         <= '0;
            bit_cnt         <= '0;
            rd_wait         <= '0;
            hdr_idx         <= 1'b0;
            qsel            <= 1'b0;
            emit_left       <= '0;
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            Done            <= 1'b0;
            Error           <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    SRAM_we_n <= 1'b1;
                    Done      <= 1'b0;
                    if (Start) begin
                        Error        <= 1'b0;
                        blk          <= '0;
                        k            <= '0;
                        bit_buf      <= '0;
                        bit_cnt      <= '0;
                        hdr_idx      <= 1'b0;
                        rd_wait      <= '0;
                        SRAM_address <= IN_BASE;
                        rd_ptr       <= IN_BASE + 18'd1;
                        state        <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (rd_wait != RD_LAT) begin
                        rd_wait <= rd_wait + 4'd1;
                    end else begin
                        rd_wait <= '0;
                        if (!hdr_idx) begin
                            if (SRAM_read_data != 16'hDEAD) begin
                                Error <= 1'b1;
                                Done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                hdr_idx      <= 1'b1;
                                SRAM_address <= rd_ptr;
                                rd_ptr       <= rd_ptr + 18'd1;
                            end
                        end else begin
                            qsel  <= SRAM_read_data[15];
                            state <= S_DECODE;
                        end
                    end
                end
                S_FILL: begin
                    if (rd_wait != RD_LAT) begin
                        rd_wait <= rd_wait + 4'd1;
                    end else begin
                        // New word lands directly below the bits still valid.
                        bit_buf <= bit_buf | ({SRAM_read_data, 16'd0} >> bit_cnt);
                        bit_cnt <= bit_cnt + 6'd16;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (bit_cnt < 6'd12) begin
                        SRAM_address <= rd_ptr;
                        rd_ptr       <= rd_ptr + 18'd1;
                        rd_wait      <= '0;
                        state        <= S_FILL;
                    end else begin
                        bit_buf         <= bit_buf << dec_len;
                        bit_cnt         <= bit_cnt - {2'd0, dec_len};
                        if (run_ovf) Error <= 1'b1;
                        SRAM_address    <= wr_addr;
                        SRAM_write_data <= dec_coef ? coef_word : 16'd0;
                        SRAM_we_n       <= 1'b0;
                        k               <= k + 7'd1;
                        emit_left       <= emit_n - 7'd1;
                        state           <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    // Only the first word of an emit can be non-zero; the rest are run zeros.
                    if (emit_left != 7'd0) begin
                        SRAM_address    <= wr_addr;
                        SRAM_write_data <= 16'd0;
                        SRAM_we_n       <= 1'b0;
                        k               <= k + 7'd1;
                        emit_left       <= emit_left - 7'd1;
                    end else begin
                        SRAM_we_n <= 1'b1;
                        state     <= (k == 7'd64) ? S_BLK_END : S_DECODE;
                    end
                end
                S_BLK_END: begin
                    k   <= '0;
                    blk <= blk + 12'd1;
                    if (blk + 12'd1 == NUM_BLOCKS) begin
                        Done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_DECODE;
                    end
                end
                S_DONE: begin
                    SRAM_we_n <= 1'b1;
                    Done      <= 1'b1;
                    if (!Start) begin
                        Done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
